window3x3_stream: RTL and testbench
===================================

Name: window3x3_stream

Overview:
- Parametrised successor to the BRAM-addressed RGB888 3x3 window generator.
- Consumes a raster-order pixel stream through a valid/ready handshake; no random BRAM reads.
- Buffers two image lines and emits one zero-padded 3x3 window per pixel (HEIGHT*WIDTH windows per frame) to the downstream MAC/conv block.
- Output side uses valid/ready backpressure, replacing the iBusy stall.

Parameters:
- DATA_W, 24, pixel width in bits (RGB888 = 24).
- WIDTH, 480, image width in pixels; legal range >= 3.
- HEIGHT, 272, image height in lines; legal range >= 2.
- COL_W, $clog2(WIDTH), column counter width (derived, do not override).
- ROW_W, $clog2(HEIGHT), row counter width (derived, do not override).

Ports:
- iClk  in  1  clock
- iRst  in  1  asynchronous active-low reset
- iStart  in  1  single-cycle frame start; honoured only in IDLE
- iValid  in  1  input pixel valid
- iPixel  in  DATA_W  input pixel, raster order
- oReady  out  1  block accepts iPixel this cycle
- oValid  out  1  oWin holds a valid window
- iReady  in  1  downstream accepts the window
- oWin  out  9*DATA_W  window; slot k at bits [k*DATA_W +: DATA_W]; k=0..8 row-major, slot 4 = centre
- oRow  out  ROW_W  centre row of the current oWin
- oCol  out  COL_W  centre column of the current oWin
- oFrameDone  out  1  one-cycle pulse after the last window of a frame is accepted

Behaviour:
- Clock and reset: single clock iClk. iRst is asynchronous active-low; it resets all state regardless of other inputs.
- Reset values: oValid=0, oReady=0, oWin=0, oRow=0, oCol=0, oFrameDone=0, state=IDLE, all counters 0. Line-buffer contents are don't-care (padding masks them).
- Handshakes: an input transfer occurs when iValid&&oReady; an output transfer occurs when oValid&&iReady.
- Output holding: while oValid&&!iReady, oWin, oRow and oCol are held stable.
- State IDLE: oReady=0. iStart clears the input and output counters and moves to PRIME.
- State PRIME: oReady=1. Accepts the first WIDTH+1 pixels with no output; moves to RUN when input index = WIDTH.
- State RUN: oReady = !oValid || iReady. Each accepted pixel at input index k produces the window for centre index k-WIDTH-1, loaded into the output register on the next cycle. The last pixel (HEIGHT-1, WIDTH-1) moves the FSM to FLUSH.
- State FLUSH: oReady=0. Generates the remaining WIDTH+1 windows internally, one per cycle whenever the output register is free. Acceptance of centre (HEIGHT-1, WIDTH-1) pulses oFrameDone and returns to IDLE.
- Latency: the window for centre index j appears one cycle after input pixel j+WIDTH+1 is accepted; in FLUSH, one cycle after the register frees.
- Throughput: with continuous valid and ready, one window per cycle.
- Padding: window taps with row<0, row>=HEIGHT, col<0 or col>=WIDTH read 0. Column padding is muxed per tap, so no state stalls occur at line ends.
- Datapath: two line buffers of depth WIDTH (rows r-1 and r) plus a 3x3 shift register. The line-buffer address is the column counter, which wraps at WIDTH-1; the row counter wraps at HEIGHT-1.
- Simultaneous events: output accept and new input in the same cycle is a legal full-rate transfer. iStart outside IDLE is ignored.
- Stalls: iValid=0 bubbles in PRIME or RUN stall the pipeline without corrupting counters.
- Reset mid-frame: the frame is aborted immediately and no oFrameDone is issued.

Optional Feature:
- Macro: WIN_EDGE_REPLICATE_EN.
- When defined: out-of-image taps take the nearest in-image pixel (clamped row and column) instead of 0.
- When undefined: zero padding as above.
- Handshake, latency and counters are identical in both builds.

Decomposition:
- Shared package win_pkg: WIN_TAPS=9, state encoding (IDLE, PRIME, RUN, FLUSH), tap index constants, and a helper function for the tap-valid/clamp index.
- One sub-module, line_buffer: single-port read-before-write RAM, DATA_W x WIDTH, with enable. It is instantiated twice, chained so the row r-1 buffer is fed from the row r buffer's read data.

Test Plan:
- Basic frame: WIDTH=4, HEIGHT=3, pixel = r*4+c+1, iReady=1, continuous iValid -> exactly 12 windows.
  - Centre (0,0) = {0,0,0,0,1,2,0,5,6}.
  - Centre (2,3) = {7,8,0,11,12,0,0,0,0}.
  - oFrameDone pulses once.
- Backpressure: hold iReady=0 for 5 cycles while centre (1,1) is presented -> oWin stays {1,2,3,5,6,7,9,10,11} with oRow=1, oCol=1; oReady=0; no pixel lost or duplicated.
- Input bubbles: drive iValid with a random 50% duty -> window sequence identical to the basic frame.
- Reset mid-frame: assert iRst after 7 input pixels -> all outputs 0 and state IDLE; a fresh iStart reproduces the basic frame.
- Start handling: iStart during FLUSH is ignored; an iStart after oFrameDone starts a second frame with identical results.
- WIN_EDGE_REPLICATE_EN build: centre (0,0) = {1,1,2,1,1,2,5,5,6}; centre (2,3) = {7,8,8,11,12,12,11,12,12}.

Source files
------------

// File: rtl/win_pkg.sv
// Shared types and helpers for the streaming 3x3 window generator.
// WIN_EDGE_REPLICATE_EN selects edge replication instead of zero padding.
package win_pkg;

    localparam int WIN_DIM  = 3;
    localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

    localparam int TAP_FIRST = 0;
    localparam int TAP_MID   = 1;
    localparam int TAP_LAST  = 2;

`ifdef WIN_EDGE_REPLICATE_EN
    localparam bit EDGE_REPLICATE = 1'b1;
`else
    localparam bit EDGE_REPLICATE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } win_state_e;

    typedef struct packed {
        logic       ok;
        logic [3:0] src;
    } tap_sel_t;

    // ok: tap lies inside the image. src: tap to read, pulled onto the centre
    // row/column when it falls outside (image is at least 3x2, so one step suffices).
    function automatic tap_sel_t tap_map(input int k, input logic top, input logic bottom,
                                         input logic left, input logic right);
        tap_sel_t s;
        int r;
        int c;
        r    = k / WIN_DIM;
        c    = k % WIN_DIM;
        s.ok = 1'b1;
        if ((r == TAP_FIRST && top) || (r == TAP_LAST && bottom)) begin
            s.ok = 1'b0;
            r    = TAP_MID;
        end
        if ((c == TAP_FIRST && left) || (c == TAP_LAST && right)) begin
            s.ok = 1'b0;
            c    = TAP_MID;
        end
        s.src = 4'(r * WIN_DIM + c);
        return s;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage. Read is combinational and the write lands on the
// clock edge, so an enabled access returns the word from the previous line.
module line_buffer #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 480,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window3x3_stream.sv
// Raster-stream 3x3 window generator with valid/ready on both sides.
// Out-of-image taps read 0, or the nearest pixel when WIN_EDGE_REPLICATE_EN is defined.
//
// state | meaning
// IDLE  | waiting for iStart, input closed
// PRIME | filling line buffers with the first WIDTH+1 pixels
// RUN   | one window per accepted pixel
// FLUSH | emitting the last WIDTH+1 windows from virtual zero pixels
module window3x3_stream
    import win_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 272,
    parameter int COL_W  = $clog2(WIDTH),
    parameter int ROW_W  = $clog2(HEIGHT)
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iStart,
    input  logic                       iValid,
    input  logic [DATA_W-1:0]          iPixel,
    output logic                       oReady,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [WIN_TAPS*DATA_W-1:0] oWin,
    output logic [ROW_W-1:0]           oRow,
    output logic [COL_W-1:0]           oCol,
    output logic                       oFrameDone
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    win_state_e state_q, state_d;
    logic [ROW_W-1:0] in_row_q, in_row_d, out_row_q, out_row_d, cen_row_q, cen_row_d;
    logic [COL_W-1:0] in_col_q, in_col_d, out_col_q, out_col_d, cen_col_q, cen_col_d;
    logic valid_q, valid_d, done_q, done_d, last_gen_q, last_gen_d;
    logic [DATA_W-1:0] sr_q [WIN_TAPS];
    logic [DATA_W-1:0] sr_d [WIN_TAPS];
    logic [WIN_TAPS*DATA_W-1:0] win_q, win_d;

    logic ready, acc, gen, clear, adv, produce;
    logic [DATA_W-1:0] pix_in, rd0, rd1;
    tap_sel_t sel;

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        acc     = 1'b0;
        gen     = 1'b0;
        clear   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    clear   = 1'b1;
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                ready = 1'b1;
                acc   = iValid;
                if (acc && in_row_q == ROW_W'(1) && in_col_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = !valid_q || iReady;
                acc   = iValid && ready;
                if (acc && in_row_q == ROW_LAST && in_col_q == COL_LAST) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                gen = !last_gen_q && (!valid_q || iReady);
                if (last_gen_q && valid_q && iReady) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        adv     = acc || gen;
        produce = (state_q == ST_RUN && acc) || gen;
    end

    always_comb begin
        in_row_d   = in_row_q;
        in_col_d   = in_col_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        cen_row_d  = cen_row_q;
        cen_col_d  = cen_col_q;
        last_gen_d = last_gen_q;
        valid_d    = valid_q;
        if (clear) begin
            in_row_d   = '0;
            in_col_d   = '0;
            out_row_d  = '0;
            out_col_d  = '0;
            last_gen_d = 1'b0;
        end else begin
            // The input column keeps stepping in FLUSH: it still addresses the line buffers.
            if (adv) begin
                if (in_col_q == COL_LAST) begin
                    in_col_d = '0;
                    in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + ROW_W'(1);
                end else begin
                    in_col_d = in_col_q + COL_W'(1);
                end
            end
            if (produce) begin
                cen_row_d = out_row_q;
                cen_col_d = out_col_q;
                if (out_row_q == ROW_LAST && out_col_q == COL_LAST) begin
                    last_gen_d = 1'b1;
                end
                if (out_col_q == COL_LAST) begin
                    out_col_d = '0;
                    out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + ROW_W'(1);
                end else begin
                    out_col_d = out_col_q + COL_W'(1);
                end
            end
        end
        if (produce) begin
            valid_d = 1'b1;
        end else if (iReady) begin
            valid_d = 1'b0;
        end
    end

    assign pix_in = (state_q == ST_FLUSH) ? '0 : iPixel;

    // Row r buffer feeds the row r-1 buffer with the word it is about to overwrite.
    line_buffer #(.DATA_W(DATA_W), .DEPTH(WIDTH), .ADDR_W(COL_W)) u_lb_cur (
        .clk_i   (iClk),
        .en_i    (adv),
        .addr_i  (in_col_q),
        .wdata_i (pix_in),
        .rdata_o (rd0)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(WIDTH), .ADDR_W(COL_W)) u_lb_prev (
        .clk_i   (iClk),
        .en_i    (adv),
        .addr_i  (in_col_q),
        .wdata_i (rd0),
        .rdata_o (rd1)
    );

    always_comb begin
        sr_d = sr_q;
        if (adv) begin
            for (int i = 0; i < WIN_DIM; i++) begin
                sr_d[i*WIN_DIM]     = sr_q[i*WIN_DIM + 1];
                sr_d[i*WIN_DIM + 1] = sr_q[i*WIN_DIM + 2];
            end
            sr_d[2] = rd1;
            sr_d[5] = rd0;
            sr_d[8] = pix_in;
        end
    end

    always_comb begin
        win_d = win_q;
        sel   = '0;
        if (produce) begin
            for (int k = 0; k < WIN_TAPS; k++) begin
                sel = tap_map(k, out_row_q == '0, out_row_q == ROW_LAST,
                              out_col_q == '0, out_col_q == COL_LAST);
                win_d[k*DATA_W +: DATA_W] = (sel.ok || EDGE_REPLICATE) ? sr_d[sel.src] : '0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= ST_IDLE;
            in_row_q   <= '0;
            in_col_q   <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            cen_row_q  <= '0;
            cen_col_q  <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            last_gen_q <= 1'b0;
            win_q      <= '0;
            for (int k = 0; k < WIN_TAPS; k++) begin
                sr_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            in_row_q   <= in_row_d;
            in_col_q   <= in_col_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            cen_row_q  <= cen_row_d;
            cen_col_q  <= cen_col_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            last_gen_q <= last_gen_d;
            win_q      <= win_d;
            sr_q       <= sr_d;
        end
    end

    assign oReady     = ready;
    assign oValid     = valid_q;
    assign oWin       = win_q;
    assign oRow       = cen_row_q;
    assign oCol       = cen_col_q;
    assign oFrameDone = done_q;

endmodule

// File: tb/tb_window3x3_stream.sv
// Directed bench for window3x3_stream on a 4x3 image of 8-bit pixels.
// Honours WIN_EDGE_REPLICATE_EN for the expected windows.
module tb_window3x3_stream;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NWIN = W * H;
    localparam int WINB = 9 * DW;

    typedef struct packed {
        logic [DW-1:0]   pixel;
        logic [1:0]      row;
        logic [1:0]      col;
        logic [WINB-1:0] win;
    } vec_t;

    // Slot 8 first in each concatenation.
`ifdef WIN_EDGE_REPLICATE_EN
    localparam logic [WINB-1:0] HAND_C00 = {8'd6, 8'd5, 8'd5, 8'd2, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1};
    localparam logic [WINB-1:0] HAND_C23 = {8'd12, 8'd12, 8'd11, 8'd12, 8'd12, 8'd11, 8'd8, 8'd8, 8'd7};
`else
    localparam logic [WINB-1:0] HAND_C00 = {8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic [WINB-1:0] HAND_C23 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd12, 8'd11, 8'd0, 8'd8, 8'd7};
`endif
    localparam logic [WINB-1:0] HAND_C11 = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};

    logic            iClk, iRst, iStart, iValid, iReady;
    logic [DW-1:0]   iPixel;
    logic            oReady, oValid, oFrameDone;
    logic [WINB-1:0] oWin;
    logic [1:0]      oRow, oCol;

    vec_t            tbl [NWIN];
    logic [WINB-1:0] cap_win [NWIN];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_idx  = 0;
    int done_cnt = 0;
    int cyc_cnt  = 0;
    int first_cyc = -1;
    int last_cyc  = -1;
    int acc5_cyc  = -1;

    window3x3_stream #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iStart     (iStart),
        .iValid     (iValid),
        .iPixel     (iPixel),
        .oReady     (oReady),
        .oValid     (oValid),
        .iReady     (iReady),
        .oWin       (oWin),
        .oRow       (oRow),
        .oCol       (oCol),
        .oFrameDone (oFrameDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc_cnt++;

    task automatic check(input string name, input logic [WINB-1:0] got, input logic [WINB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [WINB-1:0] model_win(input int r, input int c);
        logic [WINB-1:0] w;
        int rr;
        int cc;
        bit in_img;
        w = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r + dr - 1;
                cc = c + dc - 1;
                in_img = (rr >= 0 && rr < H && cc >= 0 && cc < W);
`ifdef WIN_EDGE_REPLICATE_EN
                rr = (rr < 0) ? 0 : (rr >= H) ? H - 1 : rr;
                cc = (cc < 0) ? 0 : (cc >= W) ? W - 1 : cc;
                in_img = 1'b1;
`endif
                if (in_img) w[(dr*3 + dc)*DW +: DW] = DW'(rr * W + cc + 1);
            end
        end
        return w;
    endfunction

    // Output monitor: every accepted window is checked in order against the table.
    always @(negedge iClk) begin
        if (iRst && oValid && iReady) begin
            if (exp_idx < NWIN) begin
                check("win_seq", oWin, tbl[exp_idx].win);
                check("rowcol_seq", WINB'({oRow, oCol}), WINB'({tbl[exp_idx].row, tbl[exp_idx].col}));
                cap_win[exp_idx] = oWin;
            end else begin
                check("extra_window", WINB'(exp_idx), WINB'(NWIN - 1));
            end
            if (first_cyc < 0) first_cyc = cyc_cnt;
            last_cyc = cyc_cnt;
            exp_idx++;
        end
        if (oFrameDone) begin
            done_cnt++;
            check("done_after_last", WINB'(exp_idx), WINB'(NWIN));
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, WINB'(oValid), '0);
        check({tag, "_ready"}, WINB'(oReady), '0);
        check({tag, "_win"}, oWin, '0);
        check({tag, "_row"}, WINB'(oRow), '0);
        check({tag, "_col"}, WINB'(oCol), '0);
        check({tag, "_done"}, WINB'(oFrameDone), '0);
    endtask

    task automatic feed(input int npix, input bit bubbles);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < npix && cyc < 300) begin
            iValid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            iPixel = tbl[idx].pixel;
            @(negedge iClk);
            acc = iValid && oReady;
            if (acc && idx == W + 1) acc5_cyc = cyc_cnt + 1;
            @(posedge iClk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        iValid = 1'b0;
        if (idx < npix) begin
            n_checks++;
            n_fail++;
            $display("FAIL feed_timeout: accepted %0d pixels, required %0d", idx, npix);
        end
    endtask

    task automatic start_frame();
        exp_idx   = 0;
        first_cyc = -1;
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
    endtask

    task automatic run_frame(input bit bubbles, input bit poke_start, input bit check_rate);
        int d0;
        int cyc;
        d0 = done_cnt;
        start_frame();
        feed(NWIN, bubbles);
        if (poke_start) begin
            iStart = 1'b1;
            @(posedge iClk);
            #1;
            iStart = 1'b0;
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 100) begin
            @(posedge iClk);
            #1;
            cyc++;
        end
        repeat (3) begin
            @(posedge iClk);
            #1;
        end
        check("window_count", WINB'(exp_idx), WINB'(NWIN));
        check("done_pulses", WINB'(done_cnt - d0), WINB'(1));
        check("win_c00", cap_win[0], HAND_C00);
        check("win_c23", cap_win[NWIN-1], HAND_C23);
        if (check_rate) begin
            check("full_rate", WINB'(last_cyc - first_cyc), WINB'(NWIN - 1));
            check("first_latency", WINB'(first_cyc), WINB'(acc5_cyc));
        end
        iValid = 1'b1;
        @(negedge iClk);
        check("idle_ready", WINB'(oReady), '0);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
    endtask

    task automatic backpressure();
        int cyc;
        bit found;
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 100) begin
            @(posedge iClk);
            #1;
            cyc++;
            found = oValid && oRow == 2'd1 && oCol == 2'd1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL bp_timeout: centre (1,1) not seen, required within 100 cycles");
        end else begin
            iReady = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge iClk);
                check("bp_win", oWin, HAND_C11);
                check("bp_rowcol", WINB'({oRow, oCol}), WINB'(4'b0101));
                check("bp_valid", WINB'(oValid), WINB'(1));
                check("bp_ready", WINB'(oReady), '0);
                @(posedge iClk);
                #1;
            end
            iReady = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int i = 0; i < NWIN; i++) begin
            tbl[i].pixel = DW'(i + 1);
            tbl[i].row   = 2'(i / W);
            tbl[i].col   = 2'(i % W);
            tbl[i].win   = model_win(i / W, i % W);
        end
        iRst = 1'b0; iStart = 1'b0; iValid = 1'b0; iReady = 1'b1; iPixel = '0;
        #12;
        check_reset("rst");
        @(posedge iClk);
        #1;
        iRst = 1'b1;

        run_frame(1'b0, 1'b0, 1'b1);

        fork
            run_frame(1'b0, 1'b0, 1'b0);
            backpressure();
        join

        run_frame(1'b1, 1'b0, 1'b0);

        d0 = done_cnt;
        start_frame();
        feed(7, 1'b0);
        iRst = 1'b0;
        #1;
        check_reset("rst_mid");
        @(posedge iClk);
        #1;
        iRst = 1'b1;
        iValid = 1'b1;
        @(negedge iClk);
        check("rst_idle_ready", WINB'(oReady), '0);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        check("rst_no_done", WINB'(done_cnt), WINB'(d0));
        run_frame(1'b0, 1'b0, 1'b1);

        run_frame(1'b0, 1'b1, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
